// File: rtl/chacha_aead_ks_sched.sv
// Keystream sequencer for ChaCha20-Poly1305: one-time Poly1305 key from block 0,
// then 128-bit keystream lanes from a 2-entry prefetch buffer.
module chacha_aead_ks_sched #(
    parameter int          LEN_W   = 16,
    parameter int          TIMEOUT = 1023,
    parameter logic [31:0] PK_CTR  = 32'd0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [255:0]     key,
    input  logic [95:0]      nonce,
    input  logic [LEN_W-1:0] msg_len,
    output logic             ks_cfg_we,
    output logic [255:0]     ks_key,
    output logic [95:0]      ks_nonce,
    output logic [31:0]      ks_ctr_init,
    output logic             ks_req,
    input  logic             ks_valid,
    input  logic [511:0]     ks_data,
    output logic             pk_valid,
    output logic [255:0]     pk_data,
    input  logic             pk_ready,
    output logic             lane_valid,
    output logic [127:0]     lane_data,
    input  logic             lane_ready,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, CFG, SETTLE, PK_REQ, PK_WAIT, PK_OUT, STREAM, FIN
    } state_t;

    state_t           state, state_nx;
    logic [255:0]     key_r;
    logic [95:0]      nonce_r;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] lanes_sent;
    logic [LEN_W:0]   blk_need;
    logic [LEN_W:0]   blk_got;
    logic             pend;
    logic             drop_next;
    logic [TW-1:0]    tmo;
    logic             err_r;
    logic [255:0]     pk_r;
    logic [511:0]     buf_q [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       cnt;
    logic [1:0]       lane_idx;

    logic accept, kill, resp, keep, tmo_hit;
    logic take, last_lane, pop, push, stream_req;

    assign ks_key      = key_r;
    assign ks_nonce    = nonce_r;
    assign ks_ctr_init = PK_CTR;
    assign pk_data     = pk_r;
    assign err         = err_r;
    assign lane_data   = lane_valid ? buf_q[rd_ptr][{lane_idx, 7'd0} +: 128] : '0;

    always_comb begin
        state_nx   = state;
        accept     = (state == IDLE) && start && !abort;
        kill       = abort && (state != IDLE);
        resp       = ks_valid && pend;
        keep       = resp && !drop_next;
        tmo_hit    = pend && !ks_valid && (tmo == TMO_LAST);
        ks_cfg_we  = (state == CFG);
        pk_valid   = (state == PK_OUT);
        lane_valid = (state == STREAM) && (cnt != 2'd0);
        busy       = (state != IDLE);
        done       = (state == FIN);
        take       = lane_valid && lane_ready;
        last_lane  = (lanes_sent == len_r - LEN_W'(1));
        pop        = take && ((lane_idx == 2'd3) || last_lane);
        push       = keep && (state == STREAM);
        stream_req = (state == STREAM) && !pend && (cnt != 2'd2)
                     && (blk_got < blk_need) && !abort;
        ks_req     = ((state == PK_REQ) && !drop_next && !abort) || stream_req;

        unique case (state)
            IDLE:    if (accept) state_nx = CFG;
            CFG:     state_nx = SETTLE;
            SETTLE:  state_nx = PK_REQ;
            PK_REQ:  if (!drop_next) state_nx = PK_WAIT;
            PK_WAIT: if (keep) state_nx = PK_OUT;
            PK_OUT:  if (pk_ready) state_nx = (len_r == '0) ? FIN : STREAM;
            STREAM:  if (take && last_lane) state_nx = FIN;
            FIN:     state_nx = IDLE;
        endcase
        if (kill || tmo_hit) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_r      <= '0;
            nonce_r    <= '0;
            len_r      <= '0;
            lanes_sent <= '0;
            blk_need   <= '0;
            blk_got    <= '0;
            pend       <= 1'b0;
            drop_next  <= 1'b0;
            tmo        <= '0;
            err_r      <= 1'b0;
            pk_r       <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            cnt        <= '0;
            lane_idx   <= '0;
        end else begin
            if (accept) begin
                key_r      <= key;
                nonce_r    <= nonce;
                len_r      <= msg_len;
                blk_need   <= ({1'b0, msg_len} + (LEN_W + 1)'(3)) >> 2;
                blk_got    <= '0;
                lanes_sent <= '0;
                err_r      <= 1'b0;
            end
            if (tmo_hit) err_r <= 1'b1;
            if ((state == PK_WAIT) && keep) pk_r <= ks_data[255:0];
            if (stream_req) blk_got <= blk_got + (LEN_W + 1)'(1);
            if (take) lanes_sent <= lanes_sent + LEN_W'(1);

            // An aborted in-flight request is still owed a reply; mark it for discard.
            if (tmo_hit) begin
                pend      <= 1'b0;
                drop_next <= 1'b0;
            end else begin
                if (ks_req)    pend <= 1'b1;
                else if (resp) pend <= 1'b0;
                if (resp)              drop_next <= 1'b0;
                else if (kill && pend) drop_next <= 1'b1;
            end

            if (ks_req || !pend || resp) tmo <= '0;
            else                         tmo <= tmo + TW'(1);

            if (kill || tmo_hit || accept) begin
                cnt      <= '0;
                wr_ptr   <= 1'b0;
                rd_ptr   <= 1'b0;
                lane_idx <= '0;
            end else begin
                if (push) wr_ptr <= ~wr_ptr;
                if (pop) begin
                    rd_ptr   <= ~rd_ptr;
                    lane_idx <= '0;
                end else if (take) begin
                    lane_idx <= lane_idx + 2'd1;
                end
                if (push && !pop)      cnt <= cnt + 2'd1;
                else if (pop && !push) cnt <= cnt - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) buf_q[wr_ptr] <= ks_data;
    end

endmodule

// File: tb/tb_chacha_aead_ks_sched.sv
// Bench for chacha_aead_ks_sched: a ChaCha20 keystream unit model feeds the DUT
// and lanes/poly keys are compared against blocks computed from key/nonce/counter.
module tb_chacha_aead_ks_sched;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, abort;
    logic [255:0]  key;
    logic [95:0]   nonce;
    logic [15:0]   msg_len;
    logic          ks_cfg_we;
    logic [255:0]  ks_key;
    logic [95:0]   ks_nonce;
    logic [31:0]   ks_ctr_init;
    logic          ks_req;
    logic          ks_valid;
    logic [511:0]  ks_data;
    logic          pk_valid;
    logic [255:0]  pk_data;
    logic          pk_ready;
    logic          lane_valid;
    logic [127:0]  lane_data;
    logic          lane_ready;
    logic          busy, done, err;

    chacha_aead_ks_sched #(.LEN_W(16), .TIMEOUT(15), .PK_CTR(32'd0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .key(key), .nonce(nonce), .msg_len(msg_len),
        .ks_cfg_we(ks_cfg_we), .ks_key(ks_key), .ks_nonce(ks_nonce),
        .ks_ctr_init(ks_ctr_init), .ks_req(ks_req), .ks_valid(ks_valid),
        .ks_data(ks_data), .pk_valid(pk_valid), .pk_data(pk_data),
        .pk_ready(pk_ready), .lane_valid(lane_valid), .lane_data(lane_data),
        .lane_ready(lane_ready), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    int cyc = 0;
    int req_cnt, cfg_cnt, done_cnt, overlap, buf_over, delivered, taken;
    bit withhold = 1'b0;
    int lat_lo = 1, lat_hi = 4;
    int rmode = 0;
    logic [255:0] m_key;
    logic [95:0]  m_nonce;
    logic [31:0]  m_ctr;
    logic [511:0] rq_data [$];
    int           rq_due [$];
    logic [255:0] act_pk [$];
    logic [127:0] act_lane [$];

    function automatic logic [511:0] chacha(input logic [255:0] k,
                                            input logic [95:0] n,
                                            input logic [31:0] c);
        logic [31:0] s [16];
        logic [31:0] x [16];
        logic [511:0] o;
        int qa [8];
        int qb [8];
        int qc [8];
        int qd [8];
        int a, b, cc, d;
        qa = '{0, 1, 2, 3, 0, 1, 2, 3};
        qb = '{4, 5, 6, 7, 5, 6, 7, 4};
        qc = '{8, 9, 10, 11, 10, 11, 8, 9};
        qd = '{12, 13, 14, 15, 15, 12, 13, 14};
        s[0] = 32'h61707865; s[1] = 32'h3320646e;
        s[2] = 32'h79622d32; s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s[4+i] = k[32*i +: 32];
        s[12] = c;
        for (int i = 0; i < 3; i++) s[13+i] = n[32*i +: 32];
        x = s;
        for (int r = 0; r < 10; r++) begin
            for (int j = 0; j < 8; j++) begin
                a = qa[j]; b = qb[j]; cc = qc[j]; d = qd[j];
                x[a] = x[a] + x[b]; x[d] = x[d] ^ x[a]; x[d] = {x[d][15:0], x[d][31:16]};
                x[cc] = x[cc] + x[d]; x[b] = x[b] ^ x[cc]; x[b] = {x[b][19:0], x[b][31:20]};
                x[a] = x[a] + x[b]; x[d] = x[d] ^ x[a]; x[d] = {x[d][23:0], x[d][31:24]};
                x[cc] = x[cc] + x[d]; x[b] = x[b] ^ x[cc]; x[b] = {x[b][24:0], x[b][31:25]};
            end
        end
        for (int i = 0; i < 16; i++) o[32*i +: 32] = x[i] + s[i];
        return o;
    endfunction

    function automatic logic [127:0] exp_lane(input logic [255:0] k,
                                              input logic [95:0] n, input int i);
        logic [511:0] blk;
        blk = chacha(k, n, 32'(1 + i / 4));
        return blk[128*(i%4) +: 128];
    endfunction

    function automatic logic [255:0] exp_pk(input logic [255:0] k, input logic [95:0] n);
        logic [511:0] blk;
        blk = chacha(k, n, 32'd0);
        return blk[255:0];
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // Keystream unit model and monitor; runs mid-cycle after the drivers settle.
    always @(negedge clk) begin
        #1;
        cyc++;
        ks_valid = 1'b0;
        if (!rst_n) begin
            rq_data.delete();
            rq_due.delete();
        end else begin
            if (!withhold && rq_due.size() > 0 && rq_due[0] <= cyc) begin
                ks_valid = 1'b1;
                ks_data  = rq_data.pop_front();
                void'(rq_due.pop_front());
                delivered++;
            end
            case (rmode)
                0: begin lane_ready = 1'b1; pk_ready = 1'b1; end
                1: begin lane_ready = cyc[0]; pk_ready = 1'b1; end
                default: begin
                    lane_ready = 1'($urandom_range(0, 1));
                    pk_ready   = 1'($urandom_range(0, 1));
                end
            endcase
            if (ks_cfg_we) begin
                cfg_cnt++;
                m_key = ks_key; m_nonce = ks_nonce; m_ctr = ks_ctr_init;
            end
            if (ks_req) begin
                req_cnt++;
                if (rq_due.size() != 0) overlap++;
                rq_due.push_back(cyc + int'($urandom_range(lat_lo, lat_hi)));
                rq_data.push_back(chacha(m_key, m_nonce, m_ctr));
                m_ctr++;
            end
            if (pk_valid && pk_ready) act_pk.push_back(pk_data);
            if (lane_valid && lane_ready) begin
                act_lane.push_back(lane_data);
                taken++;
            end
            if (done) done_cnt++;
            if (delivered >= 1 && (delivered - 1 - taken / 4) > 2) buf_over++;
        end
    end

    task automatic clear_stats();
        req_cnt = 0; cfg_cnt = 0; done_cnt = 0; overlap = 0;
        buf_over = 0; delivered = 0; taken = 0;
        act_pk.delete();
        act_lane.delete();
    endtask

    task automatic send_start(input logic [255:0] k, input logic [95:0] n, input int len);
        @(negedge clk);
        key = k; nonce = n; msg_len = 16'(len); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_cnt > 0 || err) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        key = '0; nonce = '0; msg_len = '0;
        ks_valid = 1'b0; ks_data = '0; pk_ready = 1'b0; lane_ready = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({busy, done, err, ks_req, ks_cfg_we, pk_valid, lane_valid} !== 7'd0) begin
            fails++;
            $display("FAIL reset_ctrl got=%b want=0",
                     {busy, done, err, ks_req, ks_cfg_we, pk_valid, lane_valid});
        end
        tests++;
        if (ks_key !== '0 || ks_nonce !== '0 || ks_ctr_init !== 32'd0) begin
            fails++;
            $display("FAIL reset_cfg key=%h nonce=%h ctr=%h want=0", ks_key, ks_nonce, ks_ctr_init);
        end
        tests++;
        if (pk_data !== '0 || lane_data !== '0) begin
            fails++;
            $display("FAIL reset_data pk=%h lane=%h want=0", pk_data, lane_data);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle busy=%b want=0", busy);
        end
    endtask

    task automatic test_rfc_pk();
        logic [255:0] k;
        logic [95:0]  n;
        bit ok;
        for (int i = 0; i < 32; i++) k[8*i +: 8] = 8'(i);
        n = 96'h000000000000004a00000000;
        rmode = 0; lat_lo = 1; lat_hi = 4;
        clear_stats();
        send_start(k, n, 0);
        wait_end(200, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL t1_end timed out want=done"); end
        tests++;
        if (cfg_cnt !== 1 || req_cnt !== 1) begin
            fails++;
            $display("FAIL t1_counts cfg=%0d req=%0d want=1/1", cfg_cnt, req_cnt);
        end
        tests++;
        if (act_pk.size() != 1 || act_pk[0] !== exp_pk(k, n)) begin
            fails++;
            $display("FAIL t1_pk n=%0d got=%h want=%h", act_pk.size(),
                     (act_pk.size() > 0) ? act_pk[0] : 256'h0, exp_pk(k, n));
        end
        tests++;
        if (done_cnt !== 1 || act_lane.size() != 0 || busy !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("FAIL t1_end done=%0d lanes=%0d busy=%b err=%b want=1/0/0/0",
                     done_cnt, act_lane.size(), busy, err);
        end
    endtask

    task automatic test_msg(input string nm, input int len, input int mode, input int hi);
        logic [255:0] k;
        logic [95:0]  n;
        bit ok;
        int nreq;
        k = rand256();
        n = {$urandom, $urandom, $urandom};
        rmode = mode; lat_lo = 1; lat_hi = hi;
        clear_stats();
        send_start(k, n, len);
        wait_end(1000, ok);
        nreq = 1 + (len + 3) / 4;
        tests++;
        if (!ok || done_cnt !== 1 || err !== 1'b0) begin
            fails++;
            $display("FAIL %s_done ok=%0d done=%0d err=%b want=1/1/0", nm, ok, done_cnt, err);
        end
        tests++;
        if (req_cnt !== nreq || overlap !== 0 || buf_over !== 0) begin
            fails++;
            $display("FAIL %s_req req=%0d ovl=%0d bufovr=%0d want=%0d/0/0",
                     nm, req_cnt, overlap, buf_over, nreq);
        end
        tests++;
        if (act_pk.size() != 1 || act_pk[0] !== exp_pk(k, n)) begin
            fails++;
            $display("FAIL %s_pk n=%0d want=1 matching", nm, act_pk.size());
        end
        tests++;
        if (act_lane.size() != len) begin
            fails++;
            $display("FAIL %s_nlanes got=%0d want=%0d", nm, act_lane.size(), len);
        end
        for (int i = 0; i < len && i < act_lane.size(); i++) begin
            tests++;
            if (act_lane[i] !== exp_lane(k, n, i)) begin
                fails++;
                $display("FAIL %s_lane%0d got=%h want=%h", nm, i, act_lane[i], exp_lane(k, n, i));
            end
        end
    endtask

    task automatic test_full_block();
        test_msg("t2", 4, 0, 4);
    endtask

    task automatic test_partial();
        test_msg("t3", 9, 1, 4);
    endtask

    task automatic test_random();
        for (int m = 0; m < 6; m++) test_msg("rnd", int'($urandom_range(0, 20)), 2, 6);
    endtask

    task automatic test_timeout();
        bit seen = 1'b0;
        bit ok;
        int n = 0;
        withhold = 1'b1;
        rmode = 0; lat_lo = 1; lat_hi = 2;
        clear_stats();
        send_start(rand256(), 96'h1, 3);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (seen) n++;
            if (!seen && ks_req) seen = 1'b1;
            if (seen && n == 15) begin
                tests++;
                if (err !== 1'b0) begin fails++; $display("FAIL t4_early err=%b want=0", err); end
            end
            if (seen && n == 16) begin
                tests++;
                if (err !== 1'b1 || busy !== 1'b0) begin
                    fails++;
                    $display("FAIL t4_err err=%b busy=%b want=1/0", err, busy);
                end
                break;
            end
        end
        tests++;
        if (!seen || done_cnt !== 0) begin
            fails++;
            $display("FAIL t4_seq req_seen=%0d done=%0d want=1/0", seen, done_cnt);
        end
        @(negedge clk);
        withhold = 1'b0;
        rq_data.delete();
        rq_due.delete();
        clear_stats();
        send_start(rand256(), 96'h2, 1);
        tests++;
        if (err !== 1'b0) begin fails++; $display("FAIL t4_clear err=%b want=0", err); end
        wait_end(200, ok);
        tests++;
        if (!ok || done_cnt !== 1 || act_lane.size() != 1 || err !== 1'b0) begin
            fails++;
            $display("FAIL t4_rerun ok=%0d done=%0d lanes=%0d err=%b want=1/1/1/0",
                     ok, done_cnt, act_lane.size(), err);
        end
    endtask

    task automatic test_abort();
        logic [255:0] k1, k2;
        logic [95:0]  n;
        bit seen = 1'b0;
        bit ok;
        k1 = rand256();
        k2 = ~k1;
        n  = {$urandom, $urandom, $urandom};
        rmode = 0; lat_lo = 12; lat_hi = 12;
        clear_stats();
        send_start(k1, n, 0);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (ks_req) seen = 1'b1;
        end
        lat_lo = 2; lat_hi = 3;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        tests++;
        if (!seen || busy !== 1'b0) begin
            fails++;
            $display("FAIL t5_abort seen=%0d busy=%b want=1/0", seen, busy);
        end
        key = k2; nonce = n; msg_len = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_end(200, ok);
        tests++;
        if (!ok || done_cnt !== 1 || req_cnt !== 2 || overlap !== 0 || err !== 1'b0) begin
            fails++;
            $display("FAIL t5_seq ok=%0d done=%0d req=%0d ovl=%0d err=%b want=1/1/2/0/0",
                     ok, done_cnt, req_cnt, overlap, err);
        end
        tests++;
        if (act_pk.size() != 1 || act_pk[0] !== exp_pk(k2, n)) begin
            fails++;
            $display("FAIL t5_pk n=%0d got=%h want=%h", act_pk.size(),
                     (act_pk.size() > 0) ? act_pk[0] : 256'h0, exp_pk(k2, n));
        end
    endtask

    task automatic test_reset_mid();
        logic [255:0] k;
        logic [95:0]  n;
        bit ok = 1'b0;
        k = rand256();
        n = {$urandom, $urandom, $urandom};
        rmode = 1; lat_lo = 1; lat_hi = 3;
        clear_stats();
        send_start(k, n, 12);
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (act_lane.size() >= 2) ok = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if (!ok || {busy, done, err, ks_req, ks_cfg_we, pk_valid, lane_valid} !== 7'd0
            || lane_data !== '0) begin
            fails++;
            $display("FAIL t6_rst streamed=%0d ctrl=%b lane=%h want=1/0/0", ok,
                     {busy, done, err, ks_req, ks_cfg_we, pk_valid, lane_valid}, lane_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_stats();
        send_start(k, n, 1);
        wait_end(200, ok);
        tests++;
        if (!ok || done_cnt !== 1 || req_cnt !== 2 || act_lane.size() != 1) begin
            fails++;
            $display("FAIL t6_rerun ok=%0d done=%0d req=%0d lanes=%0d want=1/1/2/1",
                     ok, done_cnt, req_cnt, act_lane.size());
        end
        tests++;
        if (act_lane.size() < 1 || act_lane[0] !== exp_lane(k, n, 0)) begin
            fails++;
            $display("FAIL t6_lane0 n=%0d want=matching lane", act_lane.size());
        end
    endtask

    initial begin
        test_reset();
        test_rfc_pk();
        test_full_block();
        test_partial();
        test_random();
        test_timeout();
        test_abort();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
